// File: rtl/bu2_signmag_serial_if.sv
// bu2_signmag_serial_if: word-in / result-out handshake bundle
// for the serial two's-complement to sign-magnitude converter.
interface bu2_signmag_serial_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sign,
        input  out_mag
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sign,
        output out_mag
    );
endinterface

// File: rtl/bu2_signmag_serial.sv
// bu2_signmag_serial: LSB-first serial two's-complement to sign-magnitude.
// Optional BU2_SM_BYPASS_EN: non-negative words skip the serial path.
module bu2_signmag_serial #(
    parameter int W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    bu2_signmag_serial_if.slave   bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [W-1:0]   sreg, sreg_d;
    logic [W-1:0]   res, res_d;
    logic           sign_q, sign_d;
    logic           seen, seen_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic           osign, osign_d;
    logic [W-1:0]   omag, omag_d;
    logic           b;
    logic           r;

    assign bus.in_ready  = (state == IDLE) && enable && reset;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sign  = osign;
    assign bus.out_mag   = omag;

    // Copy bits up to and including the first one, invert after it.
    assign b = sreg[0];
    assign r = (sign_q && seen) ? ~b : b;

    // Next-state and datapath update; enable=0 holds everything.
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        res_d   = res;
        sign_d  = sign_q;
        seen_d  = seen;
        cnt_d   = cnt;
        osign_d = osign;
        omag_d  = omag;
        unique case (state)
            IDLE: begin
                if (enable && bus.in_valid) begin
`ifdef BU2_SM_BYPASS_EN
                    if (!bus.in_data[W-1]) begin
                        state_d = DONE;
                        omag_d  = bus.in_data;
                        osign_d = 1'b0;
                    end else begin
                        state_d = SHIFT;
                        sreg_d  = bus.in_data;
                        sign_d  = bus.in_data[W-1];
                        seen_d  = 1'b0;
                        cnt_d   = CW'(W);
                    end
`else
                    state_d = SHIFT;
                    sreg_d  = bus.in_data;
                    sign_d  = bus.in_data[W-1];
                    seen_d  = 1'b0;
                    cnt_d   = CW'(W);
`endif
                end
            end
            SHIFT: begin
                if (enable) begin
                    sreg_d = sreg >> 1;
                    res_d  = {r, res[W-1:1]};
                    seen_d = seen | (sign_q & b);
                    cnt_d  = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        omag_d  = res_d;
                        osign_d = sign_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (enable && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sreg   <= '0;
            res    <= '0;
            sign_q <= 1'b0;
            seen   <= 1'b0;
            cnt    <= '0;
            osign  <= 1'b0;
            omag   <= '0;
        end else begin
            state  <= state_d;
            sreg   <= sreg_d;
            res    <= res_d;
            sign_q <= sign_d;
            seen   <= seen_d;
            cnt    <= cnt_d;
            osign  <= osign_d;
            omag   <= omag_d;
        end
    end
endmodule

// File: doc/bu2_signmag_serial.md
# bu2_signmag_serial

Serial two's-complement to sign-magnitude converter: the inverse path of the team's two's-complement (bu2) encoder. It accepts one W-bit two's-complement word over a valid/ready handshake and processes it LSB-first, one bit per enabled clock, using the copy-until-first-one-then-invert rule. It presents the sign and W-bit magnitude on a held output handshake. It sits between the bu2 datapath and downstream sign-magnitude consumers (display/BCD stages).

## Interface
- W, default 8: data width; legal range 2..32.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  global advance enable; when 0 the entire block freezes.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; equals (state==IDLE) && enable.
- in_data  input  W  two's-complement input word.
- out_valid  output  1  result is valid; high only in state DONE.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  sign of the last converted word (1 = negative).
- out_mag  output  W  magnitude of the last converted word, unsigned.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: in_ready=1 when enable=1. On in_valid && in_ready: capture in_data into the shift register, latch sign = in_data[W-1], clear seen_one, load bit counter = W, and go to SHIFT.
- SHIFT: each enabled cycle, take bit b = shift register LSB and produce r:
  - If sign=0, r=b.
  - If sign=1 and seen_one=0, r=b, and seen_one is set if b=1.
  - If sign=1 and seen_one=1, r=~b.
  - r is shifted into the result register from the MSB end. The counter decrements.
  - After the W-th bit, out_mag is loaded from the result register, out_sign from the latched sign, and the state goes to DONE.
- DONE: out_valid=1. out_sign and out_mag are stable. On out_ready && enable, go to IDLE. There is no back-to-back accept in the same cycle.
- Magnitude is W bits, so the most-negative input converts without overflow: 0x80 gives sign 1, mag 0x80.
- out_sign and out_mag update only on entry to DONE. They hold their previous value in IDLE and SHIFT.
- enable=0: no register changes, in_ready=0, out_valid holds its state-derived value, and out_ready is ignored.

## Timing
- Reset values: in_ready=0 while reset is asserted (reads 1 once released with enable=1), out_valid=0, out_sign=0, out_mag=0. All internal registers are 0.
- Latency (no freeze): accept edge t0; out_valid rises after edge t0+W.
- Each enable=0 cycle during SHIFT adds one cycle of latency.
- Throughput: one word per W+2 cycles when out_ready is held at 1.
- Reset mid-operation (any state): immediate return to IDLE with all outputs cleared. The in-flight word is discarded.
- in_valid in SHIFT or DONE is ignored; the source must hold it until in_ready.
- out_valid is never deasserted before an out_ready handshake, except by reset.

## Configuration
- BU2_SM_BYPASS_EN defined: a word accepted with in_data[W-1]=0 skips SHIFT. At the accept edge, out_mag=in_data, out_sign=0, and the state goes directly to DONE. Latency is 1 cycle.
- Negative words still take the full W-cycle serial path.
- BU2_SM_BYPASS_EN undefined: every word takes the W-cycle serial path regardless of sign.

## Test plan
- Reset/idle: hold reset=0 for 3 cycles with in_valid=1, then release with enable=1 -> out_valid=0, out_sign=0, out_mag=0 throughout reset; in_ready=1 once reset is released.
- Basic negatives, W=8, out_ready=1: 0xFB -> sign 1, mag 0x05; 0xFF -> 1, 0x01; 0x80 -> 1, 0x80. Each has out_valid rising exactly 8 cycles after accept.
- Non-negatives: 0x00 -> 0, 0x00; 0x7F -> 0, 0x7F. Latency is 8 cycles without BU2_SM_BYPASS_EN and 1 cycle with it.
- Backpressure/freeze:
  - 0xC3 with out_ready=0 for 5 cycles -> sign 1, mag 0x3D held stable with out_valid=1; completes one cycle after out_ready=1.
  - Dropping enable for 3 cycles mid-SHIFT delays out_valid by exactly 3 cycles with the same result.
- Reset mid-SHIFT: accept 0x9C, assert reset after 4 bits -> immediate IDLE with outputs 0. Next word 0x01 -> sign 0, mag 0x01.
- Exhaustive sweep: all 256 inputs back-to-back, checked against the reference model mag = sign ? -x : x in W bits, sign = msb. Throughput is one word per 10 cycles without bypass.
